// File: rtl/wb_stage_if.sv
// Writeback stage bus: MEM handshake, dmem read response, rd write port.
// WB_INSTRET_EN adds the 64-bit retired-instruction count.
interface wb_stage_if #(
  parameter int REGIDX_WIDTH = 5
);
  logic                    i_mem_valid;
  logic                    o_mem_ready;
  logic [REGIDX_WIDTH-1:0] i_mem_rd_addr;
  logic                    i_mem_rd_wen;
  logic [1:0]              i_mem_wb_sel;
  logic [31:0]             i_mem_alu_data;
  logic [31:0]             i_mem_pc4;
  logic [2:0]              i_mem_ld_funct3;
  logic [1:0]              i_mem_addr_lo;
  logic                    i_dmem_rvalid;
  logic [31:0]             i_dmem_rdata;
  logic [REGIDX_WIDTH-1:0] o_rd_addr;
  logic                    o_rd_wen;
  logic [31:0]             o_rd_data;
`ifdef WB_INSTRET_EN
  logic [63:0]             o_instret;
`endif

  modport slave (
    input  i_mem_valid, i_mem_rd_addr, i_mem_rd_wen,
    input  i_mem_wb_sel, i_mem_alu_data, i_mem_pc4,
    input  i_mem_ld_funct3, i_mem_addr_lo,
    input  i_dmem_rvalid, i_dmem_rdata,
`ifdef WB_INSTRET_EN
    output o_instret,
`endif
    output o_mem_ready, o_rd_addr, o_rd_wen, o_rd_data
  );

  modport master (
    output i_mem_valid, i_mem_rd_addr, i_mem_rd_wen,
    output i_mem_wb_sel, i_mem_alu_data, i_mem_pc4,
    output i_mem_ld_funct3, i_mem_addr_lo,
    output i_dmem_rvalid, i_dmem_rdata,
`ifdef WB_INSTRET_EN
    input  o_instret,
`endif
    input  o_mem_ready, o_rd_addr, o_rd_wen, o_rd_data
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: sole writer of the register-file write port.
// Optional WB_INSTRET_EN adds a 64-bit retired-instruction counter.
module wb_stage #(
  parameter int REGIDX_WIDTH = 5
) (
  input logic        i_clk,
  input logic        i_rst_n,
  wb_stage_if.slave  bus
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] WAIT_LD = 1'b1;

  logic [0:0]              state;
  logic [REGIDX_WIDTH-1:0] ld_rd;
  logic                    ld_wen;
  logic [2:0]              ld_f3;
  logic [1:0]              ld_lo;
  logic [REGIDX_WIDTH-1:0] rd_addr;
  logic                    rd_wen;
  logic [31:0]             rd_data;

  logic        accept;
  logic        is_ld;
  logic        ld_done;
  logic [31:0] nl_data;
  logic [31:0] ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign bus.o_mem_ready = (state == IDLE);
  assign accept  = bus.i_mem_valid & (state == IDLE);
  assign is_ld   = (bus.i_mem_wb_sel == 2'b01);
  assign ld_done = (state == WAIT_LD) & bus.i_dmem_rvalid;

  assign bus.o_rd_addr = rd_addr;
  assign bus.o_rd_wen  = rd_wen;
  assign bus.o_rd_data = rd_data;

  // Non-load result source; the reserved encoding falls back to ALU.
  always_comb begin
    nl_data = bus.i_mem_alu_data;
    unique case (1'b1)
      (bus.i_mem_wb_sel == 2'b10): nl_data = bus.i_mem_pc4;
      default: ;
    endcase
  end

  // Pick byte/half lane from the response word and extend by funct3.
  always_comb begin
    ld_byte = bus.i_dmem_rdata[{ld_lo, 3'b000} +: 8];
    ld_half = ld_lo[1] ? bus.i_dmem_rdata[31:16]
                       : bus.i_dmem_rdata[15:0];
    ld_data = '0;
    case (ld_f3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_data = bus.i_dmem_rdata;
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = '0;
    endcase
  end

  // FSM and registered write port; o_rd_wen is a one-cycle pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      ld_rd   <= '0;
      ld_wen  <= 1'b0;
      ld_f3   <= '0;
      ld_lo   <= '0;
      rd_addr <= '0;
      rd_wen  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_wen <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && is_ld) begin
            ld_rd  <= bus.i_mem_rd_addr;
            ld_wen <= bus.i_mem_rd_wen;
            ld_f3  <= bus.i_mem_ld_funct3;
            ld_lo  <= bus.i_mem_addr_lo;
            state  <= WAIT_LD;
          end else if (accept) begin
            rd_addr <= bus.i_mem_rd_addr;
            rd_data <= nl_data;
            rd_wen  <= bus.i_mem_rd_wen & (|bus.i_mem_rd_addr);
          end
        end
        default: begin
          if (bus.i_dmem_rvalid) begin
            rd_addr <= ld_rd;
            rd_data <= ld_data;
            rd_wen  <= ld_wen & (|ld_rd);
            state   <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef WB_INSTRET_EN
  logic [63:0] instret;
  assign bus.o_instret = instret;

  // Count every retirement, including rd=0 and rd_wen=0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) instret <= '0;
    else if ((accept & ~is_ld) | ld_done) instret <= instret + 64'd1;
  end
`else
  logic unused_ld_done;
  assign unused_ld_done = ld_done;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Randomized bench for wb_stage against a transaction-level model.
// Define WB_INSTRET_EN to also check the retirement counter.
module tb_wb_stage;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [4:0]  m_addr;
  logic [31:0] m_data;
  longint unsigned m_ret;

  wb_stage_if #(.REGIDX_WIDTH(5)) bus();

  wb_stage #(.REGIDX_WIDTH(5)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                           input logic [1:0] lo,
                                           input logic [31:0] w);
    int unsigned b;
    int unsigned h;
    b = (w >> (8 * int'(lo))) & 32'hFF;
    h = (w >> (16 * (int'(lo) / 2))) & 32'hFFFF;
    case (f3)
      3'd0: return (b >= 128) ? b - 256 : b;
      3'd1: return (h >= 32768) ? h - 65536 : h;
      3'd2: return w;
      3'd4: return b;
      3'd5: return h;
      default: return 32'd0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_instret();
`ifdef WB_INSTRET_EN
    check("instret", bus.o_instret, m_ret);
`endif
  endtask

  task automatic chk_port(input logic exp_wen);
    check("rd_wen", {63'd0, bus.o_rd_wen}, {63'd0, exp_wen});
    check("rd_addr", {59'd0, bus.o_rd_addr}, {59'd0, m_addr});
    check("rd_data", {32'd0, bus.o_rd_data}, {32'd0, m_data});
  endtask

  task automatic idle();
    bus.i_mem_valid   = 1'b0;
    bus.i_dmem_rvalid = 1'($urandom_range(0, 1));
    bus.i_dmem_rdata  = $urandom;
    step();
    bus.i_dmem_rvalid = 1'b0;
    chk_port(1'b0);
    check("idle_rdy", {63'd0, bus.o_mem_ready}, 64'd1);
    chk_instret();
  endtask

  task automatic do_op(input logic [1:0]  sel,
                       input logic [4:0]  rd,
                       input logic        wen,
                       input logic [31:0] alu,
                       input logic [31:0] pc4,
                       input logic [2:0]  f3,
                       input logic [1:0]  lo,
                       input logic [31:0] rdata,
                       input int          dly);
    check("rdy_in", {63'd0, bus.o_mem_ready}, 64'd1);
    bus.i_mem_valid     = 1'b1;
    bus.i_mem_wb_sel    = sel;
    bus.i_mem_rd_addr   = rd;
    bus.i_mem_rd_wen    = wen;
    bus.i_mem_alu_data  = alu;
    bus.i_mem_pc4       = pc4;
    bus.i_mem_ld_funct3 = f3;
    bus.i_mem_addr_lo   = lo;
    bus.i_dmem_rvalid   = 1'($urandom_range(0, 1));
    bus.i_dmem_rdata    = $urandom;
    step();
    bus.i_mem_valid    = 1'b0;
    bus.i_mem_rd_addr  = 5'($urandom);
    bus.i_mem_alu_data = $urandom;
    bus.i_dmem_rvalid  = 1'b0;
    if (sel == 2'b01) begin
      check("ld_busy", {63'd0, bus.o_mem_ready}, 64'd0);
      check("ld_wen0", {63'd0, bus.o_rd_wen}, 64'd0);
      for (int i = 0; i < dly; i++) begin
        step();
        check("ld_wait", {63'd0, bus.o_mem_ready}, 64'd0);
        check("ld_wen0", {63'd0, bus.o_rd_wen}, 64'd0);
      end
      bus.i_dmem_rvalid = 1'b1;
      bus.i_dmem_rdata  = rdata;
      step();
      bus.i_dmem_rvalid = 1'b0;
      m_data = ref_load(f3, lo, rdata);
    end else begin
      m_data = (sel == 2'b10) ? pc4 : alu;
    end
    m_addr = rd;
    m_ret  = m_ret + 1;
    chk_port(wen && (rd != 0));
    chk_instret();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_addr = '0;
    m_data = '0;
    m_ret  = 0;
    rst_n  = 1'b0;
    bus.i_mem_valid     = 1'b0;
    bus.i_mem_rd_addr   = '0;
    bus.i_mem_rd_wen    = 1'b0;
    bus.i_mem_wb_sel    = 2'b00;
    bus.i_mem_alu_data  = '0;
    bus.i_mem_pc4       = '0;
    bus.i_mem_ld_funct3 = 3'd0;
    bus.i_mem_addr_lo   = 2'd0;
    bus.i_dmem_rvalid   = 1'b0;
    bus.i_dmem_rdata    = '0;
    #2;
    check("rst_rdy", {63'd0, bus.o_mem_ready}, 64'd1);
    chk_port(1'b0);
    chk_instret();
    step();
    step();
    rst_n = 1'b1;
    step();

    do_op(2'b00, 5'd5, 1'b1, 32'hDEADBEEF, 32'h0, 3'd0, 2'd0, 32'h0, 0);
    do_op(2'b10, 5'd6, 1'b1, 32'h0, 32'h00000104, 3'd0, 2'd0, 32'h0, 0);
    idle();
    do_op(2'b01, 5'd7, 1'b1, 32'h0, 32'h0, 3'd0, 2'd2, 32'h1280FF34, 2);
    do_op(2'b01, 5'd7, 1'b1, 32'h0, 32'h0, 3'd4, 2'd2, 32'h1280FF34, 2);
    do_op(2'b01, 5'd8, 1'b1, 32'h0, 32'h0, 3'd1, 2'd3, 32'h80017FFF, 0);
    do_op(2'b01, 5'd8, 1'b1, 32'h0, 32'h0, 3'd5, 2'd0, 32'h80017FFF, 1);
    do_op(2'b01, 5'd9, 1'b1, 32'h0, 32'h0, 3'd2, 2'd3, 32'h80017FFF, 0);
    do_op(2'b00, 5'd0, 1'b1, 32'h1234, 32'h0, 3'd0, 2'd0, 32'h0, 0);
    do_op(2'b01, 5'd0, 1'b1, 32'h0, 32'h0, 3'd2, 2'd0, 32'h5555, 3);
    do_op(2'b01, 5'd3, 1'b1, 32'h0, 32'h0, 3'd7, 2'd1, 32'hFFFFFFFF, 0);
    do_op(2'b11, 5'd4, 1'b1, 32'hCAFE0001, 32'h9, 3'd0, 2'd0, 32'h0, 0);
    idle();

    bus.i_mem_valid     = 1'b1;
    bus.i_mem_wb_sel    = 2'b01;
    bus.i_mem_rd_addr   = 5'd10;
    bus.i_mem_rd_wen    = 1'b1;
    bus.i_mem_ld_funct3 = 3'd2;
    step();
    bus.i_mem_valid = 1'b0;
    check("rst_pre", {63'd0, bus.o_mem_ready}, 64'd0);
    rst_n = 1'b0;
    #1;
    m_addr = '0;
    m_data = '0;
    m_ret  = 0;
    check("rst_async", {63'd0, bus.o_mem_ready}, 64'd1);
    chk_port(1'b0);
    chk_instret();
    step();
    rst_n = 1'b1;
    bus.i_dmem_rvalid = 1'b1;
    bus.i_dmem_rdata  = 32'hABCD1234;
    step();
    bus.i_dmem_rvalid = 1'b0;
    chk_port(1'b0);
    check("rst_rdy2", {63'd0, bus.o_mem_ready}, 64'd1);
    chk_instret();

    for (int n = 0; n < 400; n++) begin
      logic [1:0] s;
      logic [2:0] f;
      if ($urandom_range(0, 4) == 0) begin
        idle();
      end else begin
        s = 2'($urandom);
        f = 3'($urandom);
        do_op(s, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0),
              $urandom, $urandom, f, 2'($urandom), $urandom,
              $urandom_range(0, 3));
      end
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
